// File: rtl/string_ctrl.sv
// String write sequencer: walks every (char, glyph row) of one descriptor, issues row-render
// commands to the string unit and turns returned pixels into clipped framebuffer writes.
module string_ctrl #(
    parameter  int unsigned GLYPH_W  = 8,
    parameter  int unsigned GLYPH_H  = 16,
    parameter  int unsigned SCREEN_W = 640,
    parameter  int unsigned SCREEN_H = 480,
    parameter  int unsigned TIMEOUT  = 64,
    localparam int unsigned AW       = 12,
    localparam int unsigned LW       = 8,
    localparam int unsigned CW       = 10,
    localparam int unsigned RW       = 4,
    localparam int unsigned PW       = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic [AW-1:0] req_text_addr,
    input  logic [LW-1:0] req_len,
    input  logic [CW-1:0] req_x,
    input  logic [CW-1:0] req_y,
    input  logic [PW-1:0] req_fg,
    input  logic [PW-1:0] req_bg,
    output logic          su_start,
    output logic [AW-1:0] su_addr,
    output logic [RW-1:0] su_delta_y,
    output logic [PW-1:0] su_fg,
    output logic [PW-1:0] su_bg,
    input  logic          su_wr,
    input  logic [LW-1:0] su_delta_x,
    input  logic [PW-1:0] su_pix,
    input  logic          su_done,
    output logic          fb_wr,
    output logic [CW-1:0] fb_x,
    output logic [CW-1:0] fb_y,
    output logic [PW-1:0] fb_pix,
    output logic          str_done,
    output logic          str_err,
    output logic          busy
);

    localparam int unsigned XW = 19;
    localparam int unsigned YW = 11;
    localparam int unsigned TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LAUNCH,
        S_WAIT,
        S_ADV,
        S_FINISH
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [AW-1:0]   r_text_addr;
    logic [LW-1:0]   r_len;
    logic [CW-1:0]   r_x;
    logic [CW-1:0]   r_y;
    logic [PW-1:0]   r_fg;
    logic [PW-1:0]   r_bg;
    logic [LW-1:0]   r_char;
    logic [RW-1:0]   r_row;
    logic [TW-1:0]   r_tmo;
    logic [LW-1:0]   w_char_nxt;
    logic [RW-1:0]   w_row_nxt;
    logic [TW-1:0]   w_tmo_nxt;
    logic            w_accept;
    logic            w_abort;
    logic            w_fb_wr;
    logic [AW-1:0]   w_addr_base;
    logic [XW-1:0]   w_px_x;
    logic [YW-1:0]   w_px_y;

    logic            r_req_ready;
    logic            r_su_start;
    logic [AW-1:0]   r_su_addr;
    logic [RW-1:0]   r_su_delta_y;
    logic            r_fb_wr;
    logic [CW-1:0]   r_fb_x;
    logic [CW-1:0]   r_fb_y;
    logic [PW-1:0]   r_fb_pix;
    logic            r_str_done;
    logic            r_str_err;
    logic            r_busy;

    // Absolute pixel position is wide enough that off-screen glyphs never wrap back on screen
    assign w_px_x      = XW'(r_x) + XW'(r_char) * XW'(GLYPH_W) + XW'(su_delta_x);
    assign w_px_y      = YW'(r_y) + YW'(r_row);
    assign w_addr_base = w_accept ? req_text_addr : r_text_addr;

    always_comb begin
        w_state_nxt = r_state;
        w_char_nxt  = r_char;
        w_row_nxt   = r_row;
        w_tmo_nxt   = r_tmo;
        w_accept    = 1'b0;
        w_abort     = 1'b0;
        w_fb_wr     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (req_valid && r_req_ready) begin
                    w_accept    = 1'b1;
                    w_char_nxt  = '0;
                    w_row_nxt   = '0;
                    w_state_nxt = (req_len == '0) ? S_FINISH : S_LAUNCH;
                end
            end
            S_LAUNCH: begin
                w_tmo_nxt   = '0;
                w_state_nxt = S_WAIT;
            end
            S_WAIT: begin
                w_fb_wr = su_wr && (w_px_x < XW'(SCREEN_W)) && (w_px_y < YW'(SCREEN_H));
                if (su_done) begin
                    w_state_nxt = S_ADV;
                end else if (r_tmo == TW'(TIMEOUT - 1)) begin
                    w_abort     = 1'b1;
                    w_state_nxt = S_IDLE;
                end else begin
                    w_tmo_nxt = r_tmo + TW'(1);
                end
            end
            S_ADV: begin
                if (r_row < RW'(GLYPH_H - 1)) begin
                    w_row_nxt   = r_row + RW'(1);
                    w_state_nxt = S_LAUNCH;
                end else if (r_char < r_len - LW'(1)) begin
                    w_row_nxt   = '0;
                    w_char_nxt  = r_char + LW'(1);
                    w_state_nxt = S_LAUNCH;
                end else begin
                    w_state_nxt = S_FINISH;
                end
            end
            S_FINISH: w_state_nxt = S_IDLE;
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    // Outputs are registered from next-state values so they line up with the state they describe
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_text_addr  <= '0;
            r_len        <= '0;
            r_x          <= '0;
            r_y          <= '0;
            r_fg         <= '0;
            r_bg         <= '0;
            r_char       <= '0;
            r_row        <= '0;
            r_tmo        <= '0;
            r_req_ready  <= 1'b0;
            r_su_start   <= 1'b0;
            r_su_addr    <= '0;
            r_su_delta_y <= '0;
            r_fb_wr      <= 1'b0;
            r_fb_x       <= '0;
            r_fb_y       <= '0;
            r_fb_pix     <= '0;
            r_str_done   <= 1'b0;
            r_str_err    <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_char  <= w_char_nxt;
            r_row   <= w_row_nxt;
            r_tmo   <= w_tmo_nxt;
            if (w_accept) begin
                r_text_addr <= req_text_addr;
                r_len       <= req_len;
                r_x         <= req_x;
                r_y         <= req_y;
                r_fg        <= req_fg;
                r_bg        <= req_bg;
            end
            // Ready stays low through the completion cycle, including a timeout abort
            r_req_ready <= (w_state_nxt == S_IDLE) && !w_abort;
            r_busy      <= (w_state_nxt != S_IDLE);
            r_su_start  <= (w_state_nxt == S_LAUNCH);
            if (w_state_nxt == S_LAUNCH) begin
                r_su_addr    <= w_addr_base + AW'(w_char_nxt);
                r_su_delta_y <= w_row_nxt;
            end
            r_fb_wr <= w_fb_wr;
            if (w_fb_wr) begin
                r_fb_x   <= w_px_x[CW-1:0];
                r_fb_y   <= w_px_y[CW-1:0];
                r_fb_pix <= su_pix;
            end
            r_str_done <= (w_state_nxt == S_FINISH) || w_abort;
            r_str_err  <= w_abort;
        end
    end

    assign req_ready  = r_req_ready;
    assign su_start   = r_su_start;
    assign su_addr    = r_su_addr;
    assign su_delta_y = r_su_delta_y;
    assign su_fg      = r_fg;
    assign su_bg      = r_bg;
    assign fb_wr      = r_fb_wr;
    assign fb_x       = r_fb_x;
    assign fb_y       = r_fb_y;
    assign fb_pix     = r_fb_pix;
    assign str_done   = r_str_done;
    assign str_err    = r_str_err;
    assign busy       = r_busy;

endmodule

// File: tb/tb_string_ctrl.sv
// Scoreboard bench for string_ctrl: a string-unit responder feeds random pixels while a
// monitor compares every su_start, fb_wr and str_done against expectations from a plain model.
`timescale 1ns/1ps
module tb_string_ctrl;

    localparam int GW  = 8;
    localparam int GH  = 16;
    localparam int SW  = 640;
    localparam int SH  = 480;
    localparam int TMO = 64;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [11:0] req_text_addr = '0;
    logic [7:0]  req_len = '0;
    logic [9:0]  req_x = '0;
    logic [9:0]  req_y = '0;
    logic [3:0]  req_fg = '0;
    logic [3:0]  req_bg = '0;
    logic        su_start;
    logic [11:0] su_addr;
    logic [3:0]  su_delta_y;
    logic [3:0]  su_fg;
    logic [3:0]  su_bg;
    logic        su_wr = 1'b0;
    logic [7:0]  su_delta_x = '0;
    logic [3:0]  su_pix = '0;
    logic        su_done = 1'b0;
    logic        fb_wr;
    logic [9:0]  fb_x;
    logic [9:0]  fb_y;
    logic [3:0]  fb_pix;
    logic        str_done;
    logic        str_err;
    logic        busy;

    string_ctrl dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_text_addr(req_text_addr),
        .req_len(req_len), .req_x(req_x), .req_y(req_y), .req_fg(req_fg), .req_bg(req_bg),
        .su_start(su_start), .su_addr(su_addr), .su_delta_y(su_delta_y),
        .su_fg(su_fg), .su_bg(su_bg),
        .su_wr(su_wr), .su_delta_x(su_delta_x), .su_pix(su_pix), .su_done(su_done),
        .fb_wr(fb_wr), .fb_x(fb_x), .fb_y(fb_y), .fb_pix(fb_pix),
        .str_done(str_done), .str_err(str_err), .busy(busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [23:0] q_start[$];
    logic [23:0] q_fb[$];
    logic        q_done[$];
    int n_checks = 0;
    int n_pass = 0;
    int n_start = 0;
    int n_fb = 0;
    int n_done = 0;
    int first_start_cyc = -1;
    int k = 0;
    bit hang = 1'b0;
    bit noise = 1'b0;
    int cur_x = 0;
    int cur_y = 0;
    int exp_fb = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Monitor: pops one expectation per observed DUT event
    initial begin : monitor
        logic [23:0] e;
        forever begin
            @(posedge clk); #1;
            if (su_start) begin
                if (n_start == 0) first_start_cyc = cyc;
                n_start++;
                if (q_start.size() == 0) check("unexpected_su_start", 32'(su_start), 0);
                else begin
                    e = q_start.pop_front();
                    check("su_start_addr_row_colour", {su_addr, su_delta_y, su_fg, su_bg}, e);
                end
            end
            if (fb_wr) begin
                n_fb++;
                if (q_fb.size() == 0) check("unexpected_fb_wr", 32'(fb_wr), 0);
                else begin
                    e = q_fb.pop_front();
                    check("fb_x_y_pix", {fb_x, fb_y, fb_pix}, e);
                end
            end
            if (str_done) begin
                n_done++;
                if (q_done.size() == 0) check("unexpected_str_done", 32'(str_done), 0);
                else check("str_err", 32'(str_err), 32'(q_done.pop_front()));
            end
        end
    end

    // String-unit model: 8 pixels per row with random gaps, done with or after the last pixel
    task automatic serve_row(input int c, input int r);
        int dx;
        int x;
        int y;
        bit both;
        bit fin;
        logic [3:0] p;
        dx = 0;
        fin = 1'b0;
        both = 1'($urandom_range(0, 1));
        @(posedge clk); #1;
        while (!fin && !reset) begin
            su_wr = 1'b0;
            su_done = 1'b0;
            if (dx < GW && $urandom_range(0, 3) != 0) begin
                p = 4'($urandom);
                su_wr = 1'b1;
                su_delta_x = 8'(dx);
                su_pix = p;
                x = cur_x + c * GW + dx;
                y = cur_y + r;
                if (x < SW && y < SH) begin
                    q_fb.push_back({10'(x), 10'(y), p});
                    exp_fb++;
                end
                dx++;
                if (dx == GW && both) begin
                    su_done = 1'b1;
                    fin = 1'b1;
                end
            end else if (dx == GW) begin
                su_done = 1'b1;
                fin = 1'b1;
            end
            @(posedge clk); #1;
        end
        su_wr = 1'b0;
        su_done = 1'b0;
    endtask

    initial begin : su_model
        int c;
        int r;
        forever begin
            @(posedge clk); #1;
            if (su_start && !reset) begin
                c = k / GH;
                r = k % GH;
                k++;
                su_wr = 1'b0;
                if (!hang) serve_row(c, r);
            end else begin
                su_wr = noise ? 1'($urandom_range(0, 1)) : 1'b0;
                su_done = noise ? 1'($urandom_range(0, 1)) : 1'b0;
                su_delta_x = 8'($urandom);
            end
        end
    end

    task automatic issue(input logic [11:0] a, input int len, input int x, input int y,
                         input bit hang_mode, output int acc_cyc);
        logic [3:0] fg;
        logic [3:0] bg;
        int t;
        fg = 4'($urandom);
        bg = 4'($urandom);
        noise = 1'b0;
        @(posedge clk); #1;
        cur_x = x;
        cur_y = y;
        k = 0;
        hang = hang_mode;
        exp_fb = 0;
        n_start = 0;
        n_fb = 0;
        n_done = 0;
        if (hang_mode) begin
            q_start.push_back({a, 4'd0, fg, bg});
            q_done.push_back(1'b1);
        end else begin
            for (int c = 0; c < len; c++)
                for (int r = 0; r < GH; r++)
                    q_start.push_back({a + 12'(c), 4'(r), fg, bg});
            q_done.push_back(1'b0);
        end
        req_text_addr = a;
        req_len = 8'(len);
        req_x = 10'(x);
        req_y = 10'(y);
        req_fg = fg;
        req_bg = bg;
        req_valid = 1'b1;
        t = 0;
        while (!req_ready && t < 200) begin
            @(posedge clk); #1;
            t++;
        end
        check("req_ready_before_accept", 32'(req_ready), 1);
        @(posedge clk); #1;
        req_valid = 1'b0;
        acc_cyc = cyc;
        check("busy_after_accept", 32'(busy), 1);
        check("ready_low_after_accept", 32'(req_ready), 0);
    endtask

    task automatic do_request(input string tag, input logic [11:0] a, input int len,
                              input int x, input int y, input bit hang_mode, input int fb_plan);
        int acc_cyc;
        int done_cyc;
        int t;
        int lim;
        issue(a, len, x, y, hang_mode, acc_cyc);
        lim = len * GH * 40 + 300;
        t = 0;
        while (!str_done && t < lim) begin
            @(posedge clk); #1;
            t++;
        end
        check({tag, "_str_done_seen"}, 32'(str_done), 1);
        done_cyc = cyc;
        check({tag, "_ready_low_at_done"}, 32'(req_ready), 0);
        @(posedge clk); #1;
        check({tag, "_ready_after_done"}, 32'(req_ready), 1);
        check({tag, "_idle_after_done"}, 32'(busy), 0);
        repeat (3) @(posedge clk);
        #1;
        check({tag, "_su_start_count"}, 32'(n_start), hang_mode ? 1 : 32'(len * GH));
        check({tag, "_fb_count_model"}, 32'(n_fb), 32'(exp_fb));
        if (fb_plan >= 0) check({tag, "_fb_count_plan"}, 32'(n_fb), 32'(fb_plan));
        check({tag, "_done_count"}, 32'(n_done), 1);
        check({tag, "_queues_drained"}, 32'(q_start.size() + q_fb.size() + q_done.size()), 0);
        if (len > 0) check({tag, "_first_start_latency"}, 32'(first_start_cyc), 32'(acc_cyc));
        if (hang_mode) check({tag, "_timeout_latency"}, 32'(done_cyc - first_start_cyc), 32'(TMO + 1));
        noise = 1'b1;
    endtask

    initial begin : main
        int acc_cyc;
        int nfb_at;
        int t;
        reset = 1'b1;
        repeat (3) begin
            @(posedge clk); #1;
            check("reset_ctrl_outs", {26'd0, req_ready, su_start, fb_wr, str_done, str_err, busy}, 0);
            check("reset_su_outs", {su_addr, su_delta_y, su_fg, su_bg}, 0);
            check("reset_fb_outs", {fb_x, fb_y, fb_pix}, 0);
        end
        reset = 1'b0;
        @(posedge clk); #1;
        check("ready_after_reset", 32'(req_ready), 1);
        check("busy_after_reset", 32'(busy), 0);
        noise = 1'b1;
        repeat (6) @(posedge clk);

        do_request("nominal", 12'h010, 1, 100, 50, 1'b0, 128);
        do_request("wrap", 12'hFFE, 4, 20, 200, 1'b0, 512);
        do_request("clip", 12'h123, 2, 636, 470, 1'b0, 40);
        do_request("timeout", 12'h200, 3, 10, 10, 1'b1, 0);
        do_request("zero_len", 12'h300, 0, 0, 0, 1'b0, 0);
        for (int i = 0; i < 4; i++)
            do_request("random", 12'($urandom), $urandom_range(1, 3),
                       $urandom_range(0, 1023), $urandom_range(0, 1023), 1'b0, -1);

        // Reset in the middle of char 1 of a three-char string
        issue(12'h0A0, 3, 300, 100, 1'b0, acc_cyc);
        t = 0;
        while (k < GH + 3 && t < 3000) begin
            @(posedge clk); #2;
            t++;
        end
        repeat (3) @(posedge clk);
        #2;
        reset = 1'b1;
        @(posedge clk);
        q_start.delete();
        q_fb.delete();
        q_done.delete();
        #1;
        check("abort_busy", 32'(busy), 0);
        check("abort_str_done", 32'(str_done), 0);
        check("abort_fb_wr", 32'(fb_wr), 0);
        check("abort_su_start", 32'(su_start), 0);
        nfb_at = n_fb;
        @(posedge clk); #1;
        reset = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        check("abort_no_more_fb", 32'(n_fb), 32'(nfb_at));
        check("abort_no_str_done", 32'(n_done), 0);
        check("abort_ready_back", 32'(req_ready), 1);
        do_request("recover", 12'h7F0, 2, 50, 460, 1'b0, -1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin : watchdog
        #900000;
        $display("FAIL watchdog: simulation exceeded its time limit");
        $fatal(1);
    end

endmodule
